jttrack_objram_arb: RTL

Read-port arbiter and page controller for the double-buffered sprite table RAMs of the Track & Field object path. It shares the single table read port between the per-line object scanner, an auxiliary reader (row-scroll/debug), and the ioctl RAM dump, and owns the CPU/scan page-select bit (`obj_frame`), deferring page swaps to vertical blank. It sits between the object scanner/drawer sequencer and the two table RAM instances.

---
 rtl/jttrack_objram_arb_if.sv | 23 ++
 rtl/jttrack_objram_arb.sv | 135 +++++++++++++
 2 files changed

// File: rtl/jttrack_objram_arb_if.sv
// Read-port bundle between the object scanner/aux reader and the sprite table arbiter.
interface jttrack_objram_arb_if;
    logic       scan_req;
    logic [9:0] scan_addr;
    logic       scan_ack;
    logic       scan_dv;
    logic       aux_req;
    logic [9:0] aux_addr;
    logic       aux_ack;
    logic       aux_dv;
    logic [7:0] rd_dout;
    logic       rd_page;

    modport master (
        output scan_req, scan_addr, aux_req, aux_addr,
        input  scan_ack, scan_dv, aux_ack, aux_dv, rd_dout, rd_page
    );

    modport slave (
        input  scan_req, scan_addr, aux_req, aux_addr,
        output scan_ack, scan_dv, aux_ack, aux_dv, rd_dout, rd_page
    );
endinterface

// File: rtl/jttrack_objram_arb.sv
// Sprite table read-port arbiter (scan / aux / ioctl dump) and page-select owner.
// JTTRACK_VBL_SWAP_EN defers obj_frame updates to the LVBL falling edge.
module jttrack_objram_arb #(
    parameter logic [3:0] MAXRUN = 4'd8
) (
    input  logic                        rst,
    input  logic                        clk,
    input  logic                        LVBL,
    input  logic                        frame_wr,
    input  logic                        frame_din,
    output logic                        obj_frame,
    jttrack_objram_arb_if.slave         bus,
    input  logic                        ioctl_ram,
    input  logic [9:0]                  ioctl_addr,
    output logic [9:0]                  ram_addr,
    input  logic [7:0]                  ram_q,
    output logic [1:0]                  owner
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StAux  = 2'd2,
        StDump = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       dump_mode;
    logic       scan_go, aux_go, run_full;
    logic [9:0] addr_r;
    logic       rd_page_q;
    logic [1:0] tag_q;       // {aux, scan} owner of the read the RAM is sampling
    logic       scan_dv_q, aux_dv_q;
    logic [7:0] dout_q;

    assign run_full = (MAXRUN != 4'd0) && (run_q == MAXRUN);

    always_comb begin
        state_d = StIdle;
        scan_go = 1'b0;
        aux_go  = 1'b0;
        run_d   = run_q;
        if (ioctl_ram || dump_mode) begin
            state_d = StDump;
        end else if (bus.scan_req && !(bus.aux_req && run_full)) begin
            state_d = StScan;
            scan_go = 1'b1;
        end else if (bus.aux_req) begin
            state_d = StAux;
            aux_go  = 1'b1;
        end
        // Count only scan grants that made a waiting aux request wait longer
        if (!bus.aux_req || aux_go) begin
            run_d = 4'd0;
        end else if (scan_go && run_q != MAXRUN) begin
            run_d = run_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            run_q     <= 4'd0;
            dump_mode <= 1'b0;
            addr_r    <= 10'd0;
            rd_page_q <= 1'b0;
            tag_q     <= 2'b00;
            scan_dv_q <= 1'b0;
            aux_dv_q  <= 1'b0;
            dout_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            dump_mode <= ioctl_ram;
            if (scan_go) begin
                addr_r <= bus.scan_addr;
            end else if (aux_go) begin
                addr_r <= bus.aux_addr;
            end
            if (scan_go || aux_go) begin
                rd_page_q <= ~obj_frame;
            end
            tag_q     <= {state_q == StAux, state_q == StScan};
            scan_dv_q <= tag_q[0];
            aux_dv_q  <= tag_q[1];
            if (|tag_q) begin
                dout_q <= ram_q;
            end
        end
    end

    assign owner        = state_q;
    assign bus.scan_ack = (state_q == StScan);
    assign bus.aux_ack  = (state_q == StAux);
    assign bus.scan_dv  = scan_dv_q;
    assign bus.aux_dv   = aux_dv_q;
    assign bus.rd_dout  = dout_q;
    assign bus.rd_page  = rd_page_q;
    assign ram_addr     = dump_mode ? ioctl_addr : addr_r;

`ifdef JTTRACK_VBL_SWAP_EN
    logic pending;
    logic lvbl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            lvbl_q    <= 1'b0;
            obj_frame <= 1'b0;
        end else begin
            lvbl_q <= LVBL;
            if (frame_wr) begin
                pending <= frame_din;
            end
            // A write landing on the blanking edge itself takes effect immediately
            if (lvbl_q && !LVBL) begin
                obj_frame <= frame_wr ? frame_din : pending;
            end
        end
    end
`else
    logic unused_lvbl;
    assign unused_lvbl = LVBL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obj_frame <= 1'b0;
        end else if (frame_wr) begin
            obj_frame <= frame_din;
        end
    end
`endif

endmodule
